// File: rtl/stack_param_if.sv
// Command/response bundle for stack_param: the bus master issues commands and the stack returns data and status.
interface stack_param_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 5
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [1:0]       COMMAND;
   logic [IDX_W-1:0] INDEX;
   logic [WIDTH-1:0] I_DATA;
   logic [WIDTH-1:0] O_DATA;
   logic             O_VALID;
   logic [IDX_W:0]   COUNT;
   logic             FULL;
   logic             EMPTY;
   logic             ERROR;

   modport master (
      output COMMAND, INDEX, I_DATA,
      input  O_DATA, O_VALID, COUNT, FULL, EMPTY, ERROR
   );

   modport slave (
      input  COMMAND, INDEX, I_DATA,
      output O_DATA, O_VALID, COUNT, FULL, EMPTY, ERROR
   );
endinterface

// File: rtl/stack_param.sv
// Parametrised LIFO stack on a DEPTH-entry ring with registered outputs, occupancy and error reporting.
// Define STACK_FULL_GUARD_EN to reject pushes while full instead of overwriting the oldest entry.
module stack_param #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 5
) (
   input  logic         CLK,
   input  logic         RESET,
   stack_param_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int SUM_W = IDX_W + 2;

   localparam logic [IDX_W-1:0] PTR_ZERO  = IDX_W'(0);
   localparam logic [IDX_W-1:0] PTR_ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W:0]   CNT_ZERO  = (IDX_W + 1)'(0);
   localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W + 1)'(1);
   localparam logic [IDX_W:0]   CNT_DEPTH = (IDX_W + 1)'(DEPTH);
   localparam logic [SUM_W-1:0] SUM_DEPTH = SUM_W'(DEPTH);
   localparam logic [SUM_W-1:0] SUM_LAST  = SUM_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      CMD_NOP  = 2'd0,
      CMD_PUSH = 2'd1,
      CMD_POP  = 2'd2,
      CMD_GET  = 2'd3
   } cmd_e;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0] top_q, top_d;
   logic [IDX_W:0]   count_q, count_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             error_q, error_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             mem_we_s;
   logic             full_s;
   logic [IDX_W-1:0] rd_depth_s;
   logic [IDX_W-1:0] rd_addr_s;
   cmd_e             cmd_s;

   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
      if (p == PTR_LAST) begin
         return PTR_ZERO;
      end else begin
         return p + PTR_ONE;
      end
   endfunction

   function automatic logic [IDX_W-1:0] ptr_dec(input logic [IDX_W-1:0] p);
      if (p == PTR_ZERO) begin
         return PTR_LAST;
      end else begin
         return p - PTR_ONE;
      end
   endfunction

   // Slot holding the entry 'depth' below the top: (top - 1 - depth) mod DEPTH.
   // Only meaningful for depth < COUNT; anything else is folded to slot 0.
   function automatic logic [IDX_W-1:0] slot_below_top(input logic [IDX_W-1:0] top,
                                                       input logic [IDX_W-1:0] depth);
      logic [SUM_W-1:0] sum;
      logic [SUM_W-1:0] wrapped;
      sum = {2'b00, top} + SUM_LAST - {2'b00, depth};
      if (sum >= SUM_DEPTH) begin
         wrapped = sum - SUM_DEPTH;
      end else begin
         wrapped = sum;
      end
      if (wrapped < SUM_DEPTH) begin
         return wrapped[IDX_W-1:0];
      end else begin
         return PTR_ZERO;
      end
   endfunction

   assign cmd_s      = cmd_e'(bus.COMMAND);
   assign full_s     = (count_q == CNT_DEPTH);
   assign rd_depth_s = (cmd_s == CMD_GET) ? bus.INDEX : PTR_ZERO;
   assign rd_addr_s  = slot_below_top(top_q, rd_depth_s);

   // Command decode: next pointer, occupancy, read data and status strobes.
   always_comb begin
      top_d    = top_q;
      count_d  = count_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      error_d  = 1'b0;
      mem_we_s = 1'b0;
      case (cmd_s)
         CMD_NOP: begin
            valid_d = 1'b0;
         end
         CMD_PUSH: begin
`ifdef STACK_FULL_GUARD_EN
            if (full_s) begin
               error_d = 1'b1;
            end else begin
               mem_we_s = 1'b1;
               top_d    = ptr_inc(top_q);
               count_d  = count_q + CNT_ONE;
            end
`else
            mem_we_s = 1'b1;
            top_d    = ptr_inc(top_q);
            if (full_s) begin
               count_d = count_q;
            end else begin
               count_d = count_q + CNT_ONE;
            end
`endif
         end
         CMD_POP: begin
            if (count_q != CNT_ZERO) begin
               data_d  = mem_q[rd_addr_s];
               top_d   = ptr_dec(top_q);
               count_d = count_q - CNT_ONE;
               valid_d = 1'b1;
            end else begin
               error_d = 1'b1;
            end
         end
         CMD_GET: begin
            if ({1'b0, bus.INDEX} < count_q) begin
               data_d  = mem_q[rd_addr_s];
               valid_d = 1'b1;
            end else begin
               error_d = 1'b1;
            end
         end
         default: begin
            error_d = 1'b0;
         end
      endcase
      full_d  = (count_d == CNT_DEPTH);
      empty_d = (count_d == CNT_ZERO);
   end

   // Control and output registers; RESET discards the command of the same cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         top_q   <= PTR_ZERO;
         count_q <= CNT_ZERO;
         data_q  <= {WIDTH{1'b0}};
         valid_q <= 1'b0;
         error_q <= 1'b0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         top_q   <= top_d;
         count_q <= count_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         error_q <= error_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   // Storage ring; contents survive reset but are unreachable while empty.
   always_ff @(posedge CLK) begin
      if (!RESET && mem_we_s) begin
         mem_q[top_q] <= bus.I_DATA;
      end
   end

   assign bus.O_DATA  = data_q;
   assign bus.O_VALID = valid_q;
   assign bus.ERROR   = error_q;
   assign bus.COUNT   = count_q;
   assign bus.FULL    = full_q;
   assign bus.EMPTY   = empty_q;
endmodule

// File: doc/stack_param.md
Name: stack_param

Overview:
- Parametrised LIFO stack with registered outputs, occupancy tracking and error signalling.
- Successor to the fixed 5-deep, 4-bit stack; same command encoding (nop/push/pop/get-by-depth), now with arbitrary WIDTH and DEPTH, including non-power-of-2 DEPTH.
- Storage is a ring of DEPTH entries addressed by a top pointer using explicit modulo-DEPTH arithmetic.
- Adds COUNT/FULL/EMPTY status, a one-cycle ERROR pulse and an O_VALID strobe.

Parameters:
- WIDTH, 4, data bits per entry.
- DEPTH, 5, number of entries (>=2; need not be a power of 2).
- IDX_W, $clog2(DEPTH), width of the pointer and of INDEX (derived; not overridden).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- COMMAND  input  2  0=nop, 1=push, 2=pop, 3=get.
- INDEX  input  IDX_W  get depth: 0=top, 1=one below top, ...
- I_DATA  input  WIDTH  push data.
- O_DATA  output  WIDTH  registered read data.
- O_VALID  output  1  one-cycle strobe: O_DATA updated by a successful pop or get.
- COUNT  output  IDX_W+1  entries held, 0..DEPTH.
- FULL  output  1  COUNT==DEPTH.
- EMPTY  output  1  COUNT==0.
- ERROR  output  1  one-cycle pulse: command rejected.

Behaviour:
- Reset: one clock, synchronous, active-high; RESET sampled high at a rising edge.
  - Values after reset: TOP=0, COUNT=0, O_DATA=0, O_VALID=0, ERROR=0, EMPTY=1, FULL=0.
  - Memory contents are not cleared; they are unreachable while COUNT=0.
  - RESET overrides any COMMAND in the same cycle; that command is discarded.
- TOP is the next free slot. All index arithmetic is mod DEPTH: (DEPTH-1)+1 wraps to 0, and 0-1 wraps to DEPTH-1.
- Latency: command sampled at edge N. Memory, TOP, COUNT, O_DATA, O_VALID and ERROR update at edge N; results are visible in cycle N+1.
- FULL and EMPTY are decoded from the registered COUNT.
- Push:
  - mem[TOP]<=I_DATA; TOP<=TOP+1.
  - COUNT<=min(COUNT+1, DEPTH).
  - When FULL, the oldest entry is overwritten (ring behaviour). COUNT stays DEPTH; no ERROR.
- Pop:
  - If COUNT>0: O_DATA<=mem[TOP-1]; TOP<=TOP-1; COUNT<=COUNT-1; O_VALID=1.
  - If COUNT==0: ERROR=1, O_VALID=0; TOP, COUNT and O_DATA unchanged.
- Get:
  - If INDEX<COUNT: O_DATA<=mem[TOP-1-INDEX]; O_VALID=1; TOP and COUNT unchanged.
  - If INDEX>=COUNT: ERROR=1, O_VALID=0; O_DATA holds. This also covers INDEX>=DEPTH.
- Nop: state and O_DATA hold; O_VALID=0, ERROR=0.
- O_VALID and ERROR are never high in the same cycle. Both are 0 in any cycle after a cycle with no qualifying command.
- Back-to-back commands are supported every cycle with no bubbles. Push followed by pop in the next cycle returns the pushed value.

Optional Feature:
- Macro: STACK_FULL_GUARD_EN.
- Defined: push while FULL is rejected. ERROR=1 for one cycle; memory, TOP and COUNT are unchanged; the oldest entry is preserved.
- Undefined: push while FULL overwrites the oldest entry as described in Behaviour, with no ERROR.
- All other behaviour is identical in both builds.

Test Plan:
- Basic push/pop: WIDTH=4, DEPTH=5. Reset, push 1,2,3 -> COUNT=3, EMPTY=0. Pop -> next cycle O_DATA=3, O_VALID=1, COUNT=2.
- Get by depth: push 1,2,3, then get INDEX=1 -> O_DATA=2, O_VALID=1, COUNT=3. Then get INDEX=3 -> ERROR=1, O_VALID=0, O_DATA stays 2.
- Full ring wrap (macro off): push 1..6 -> FULL=1, COUNT=5. Get INDEX=4 -> O_DATA=2. Pops return 6,5,4,3,2. A 6th pop -> ERROR=1, EMPTY=1.
- Full guard (macro on): push 1..6 -> 6th push gives ERROR=1, COUNT=5. Get INDEX=4 -> O_DATA=1. Get INDEX=0 -> O_DATA=5.
- Empty underflow: after reset, pop -> ERROR=1, O_VALID=0, O_DATA=0, COUNT=0. A following push 9 then pop -> O_DATA=9.
- Reset mid-operation: push 1,2, then RESET=1 with COMMAND=push, I_DATA=7 -> COUNT=0, EMPTY=1, O_DATA=0. The next get INDEX=0 -> ERROR=1.
